// File: rtl/axis_fifo_wr_arbiter_if.sv
// Bundles the two ingress AXI-Stream ports, the shared FIFO write port and
// the status outputs of axis_fifo_wr_arbiter.
interface axis_fifo_wr_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   logic [DATA_WIDTH-1:0] S0_TDATA_I;
   logic                  S0_TVALID_I;
   logic                  S0_TLAST_I;
   logic                  S0_TREADY_O;
   logic [DATA_WIDTH-1:0] S1_TDATA_I;
   logic                  S1_TVALID_I;
   logic                  S1_TLAST_I;
   logic                  S1_TREADY_O;
   logic                  FIFO_WR_EN_O;
   logic [DATA_WIDTH+1:0] FIFO_WR_DATA_O;
   logic                  FIFO_FULL_I;
   logic [1:0]            GRANT_O;
   logic [CNT_WIDTH-1:0]  PKT_CNT0_O;
   logic [CNT_WIDTH-1:0]  PKT_CNT1_O;

   // Arbiter side
   modport slave (
      input  S0_TDATA_I, S0_TVALID_I, S0_TLAST_I,
      input  S1_TDATA_I, S1_TVALID_I, S1_TLAST_I,
      input  FIFO_FULL_I,
      output S0_TREADY_O, S1_TREADY_O,
      output FIFO_WR_EN_O, FIFO_WR_DATA_O,
      output GRANT_O, PKT_CNT0_O, PKT_CNT1_O
   );

   // Environment side: sources, FIFO and status consumer
   modport master (
      output S0_TDATA_I, S0_TVALID_I, S0_TLAST_I,
      output S1_TDATA_I, S1_TVALID_I, S1_TLAST_I,
      output FIFO_FULL_I,
      input  S0_TREADY_O, S1_TREADY_O,
      input  FIFO_WR_EN_O, FIFO_WR_DATA_O,
      input  GRANT_O, PKT_CNT0_O, PKT_CNT1_O
   );
endinterface

// File: rtl/axis_fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one FIFO write port between two
// AXI-Stream sources; stored words are tagged {TLAST, SRC_ID, TDATA}.
module axis_fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input logic CLK_I,
   input logic RST_I,
   axis_fifo_wr_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t                state_reg, state_next;
   logic                  prio_reg, prio_next;
   logic [1:0]            tvalid, tlast, done;
   logic [DATA_WIDTH-1:0] tdata [2];
   logic                  active, sel, rdy, xfer;

   assign tvalid   = {bus.S1_TVALID_I, bus.S0_TVALID_I};
   assign tlast    = {bus.S1_TLAST_I, bus.S0_TLAST_I};
   assign tdata[0] = bus.S0_TDATA_I;
   assign tdata[1] = bus.S1_TDATA_I;

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_reg <= IDLE;
         prio_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         prio_reg  <= prio_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      prio_next  = prio_reg;
      active     = 1'b0;
      sel        = 1'b0;
      done       = 2'b00;
      case (state_reg)
         IDLE: begin
            // FIFO_FULL_I deliberately plays no part in choosing a winner
            if (&tvalid)        state_next = prio_reg ? GNT1 : GNT0;
            else if (tvalid[0]) state_next = GNT0;
            else if (tvalid[1]) state_next = GNT1;
         end
         GNT0: begin
            active = 1'b1;
            sel    = 1'b0;
         end
         GNT1: begin
            active = 1'b1;
            sel    = 1'b1;
         end
         default: state_next = IDLE;
      endcase

      rdy  = active && !bus.FIFO_FULL_I;
      xfer = rdy && tvalid[sel];
      if (xfer && tlast[sel]) begin
         state_next = IDLE;
         prio_next  = ~sel;
         done[sel]  = 1'b1;
      end

      bus.S0_TREADY_O    = rdy && !sel;
      bus.S1_TREADY_O    = rdy && sel;
      bus.FIFO_WR_EN_O   = xfer;
      bus.FIFO_WR_DATA_O = active ? {tlast[sel], sel, tdata[sel]} : '0;
      bus.GRANT_O        = {active && sel, active && !sel};
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic [CNT_WIDTH-1:0] cnt_reg;
         // Free-running wrap; a packet cut short by reset is never counted
         always_ff @(posedge CLK_I or posedge RST_I) begin
            if (RST_I)         cnt_reg <= '0;
            else if (done[gi]) cnt_reg <= cnt_reg + CNT_WIDTH'(1);
         end
      end
   endgenerate

   assign bus.PKT_CNT0_O = g_cnt[0].cnt_reg;
   assign bus.PKT_CNT1_O = g_cnt[1].cnt_reg;
endmodule

// File: tb/tb_axis_fifo_wr_arbiter.sv
// Scoreboard bench: tests queue hand-computed FIFO words, a negedge monitor
// pops and compares on every FIFO write.
module tb_axis_fifo_wr_arbiter;
   localparam int DW = 32;
   localparam int CW = 2;
   localparam int WW = DW + 2;

   logic CLK_I = 1'b0;
   logic RST_I = 1'b0;
   always #5 CLK_I = ~CLK_I;

   axis_fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   axis_fifo_wr_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .CLK_I(CLK_I),
      .RST_I(RST_I),
      .bus  (bus.slave)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [WW-1:0] exp_q [$];
   logic [DW:0]   s0_q [$];
   logic [DW:0]   s1_q [$];
   int            wr_cyc [$];

   function automatic logic [WW-1:0] w(input logic last, input logic id, input logic [DW-1:0] d);
      return {last, id, d};
   endfunction

   task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
      else $display("ok   %s: %h", nm, act);
   endtask

   // Monitor: every FIFO write must match the head of the scoreboard
   initial begin
      forever begin
         @(negedge CLK_I);
         cyc++;
         if (!RST_I && bus.FIFO_WR_EN_O) begin
            wr_cyc.push_back(cyc);
            chk("wr_en_vs_full", WW'(bus.FIFO_FULL_I), '0);
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write: got %h expected none", bus.FIFO_WR_DATA_O);
            end else begin
               chk("fifo_word", bus.FIFO_WR_DATA_O, exp_q.pop_front());
            end
         end
      end
   end

   // Source drivers: handshake sampled at negedge, next beat presented after posedge
   initial begin
      logic f;
      bus.S0_TVALID_I = 1'b0; bus.S0_TDATA_I = '0; bus.S0_TLAST_I = 1'b0;
      forever begin
         @(negedge CLK_I);
         f = bus.S0_TVALID_I && bus.S0_TREADY_O;
         @(posedge CLK_I);
         #1;
         if (f && s0_q.size() > 0) void'(s0_q.pop_front());
         if (s0_q.size() > 0) begin
            bus.S0_TVALID_I = 1'b1;
            {bus.S0_TLAST_I, bus.S0_TDATA_I} = s0_q[0];
         end else begin
            bus.S0_TVALID_I = 1'b0; bus.S0_TDATA_I = '0; bus.S0_TLAST_I = 1'b0;
         end
      end
   end

   initial begin
      logic f;
      bus.S1_TVALID_I = 1'b0; bus.S1_TDATA_I = '0; bus.S1_TLAST_I = 1'b0;
      forever begin
         @(negedge CLK_I);
         f = bus.S1_TVALID_I && bus.S1_TREADY_O;
         @(posedge CLK_I);
         #1;
         if (f && s1_q.size() > 0) void'(s1_q.pop_front());
         if (s1_q.size() > 0) begin
            bus.S1_TVALID_I = 1'b1;
            {bus.S1_TLAST_I, bus.S1_TDATA_I} = s1_q[0];
         end else begin
            bus.S1_TVALID_I = 1'b0; bus.S1_TDATA_I = '0; bus.S1_TLAST_I = 1'b0;
         end
      end
   end

   task automatic do_reset();
      s0_q.delete();
      s1_q.delete();
      exp_q.delete();
      bus.FIFO_FULL_I = 1'b0;
      RST_I = 1'b1;
      repeat (2) @(negedge CLK_I);
      RST_I = 1'b0;
      wr_cyc.delete();
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((exp_q.size() != 0 || s0_q.size() != 0 || s1_q.size() != 0) && n < 200) begin
         @(posedge CLK_I);
         n++;
      end
      if (n >= 200) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: got %0d words pending expected 0", nm, exp_q.size());
         exp_q.delete(); s0_q.delete(); s1_q.delete();
      end
      @(posedge CLK_I);
      #2;
   endtask

   initial begin
      bus.FIFO_FULL_I = 1'b0;

      // Reset state
      RST_I = 1'b1;
      #1;
      chk("rst_grant", WW'(bus.GRANT_O), '0);
      chk("rst_cnt0", WW'(bus.PKT_CNT0_O), '0);
      chk("rst_cnt1", WW'(bus.PKT_CNT1_O), '0);
      chk("rst_ready", WW'({bus.S1_TREADY_O, bus.S0_TREADY_O}), '0);
      chk("rst_wr_en", WW'(bus.FIFO_WR_EN_O), '0);
      chk("rst_wr_data", bus.FIFO_WR_DATA_O, '0);
      do_reset();

      // 1: single source, 3 beats
      for (int i = 0; i < 3; i++) begin
         s0_q.push_back({(i == 2), 32'hA0 + 32'(i)});
         exp_q.push_back(w(i == 2, 1'b0, 32'hA0 + 32'(i)));
      end
      drain("t1");
      chk("t1_gap01", WW'(wr_cyc[1] - wr_cyc[0]), WW'(1));
      chk("t1_gap12", WW'(wr_cyc[2] - wr_cyc[1]), WW'(1));
      chk("t1_cnt0", WW'(bus.PKT_CNT0_O), WW'(1));
      chk("t1_grant", WW'(bus.GRANT_O), '0);

      // 2: contention after reset, S0 first then one bubble then S1
      do_reset();
      s0_q.push_back({1'b0, 32'h10}); s0_q.push_back({1'b1, 32'h11});
      s1_q.push_back({1'b0, 32'h20}); s1_q.push_back({1'b1, 32'h21});
      exp_q.push_back(w(0, 0, 32'h10)); exp_q.push_back(w(1, 0, 32'h11));
      exp_q.push_back(w(0, 1, 32'h20)); exp_q.push_back(w(1, 1, 32'h21));
      drain("t2");
      chk("t2_gap01", WW'(wr_cyc[1] - wr_cyc[0]), WW'(1));
      chk("t2_gap12", WW'(wr_cyc[2] - wr_cyc[1]), WW'(2));
      chk("t2_gap23", WW'(wr_cyc[3] - wr_cyc[2]), WW'(1));
      chk("t2_cnt0", WW'(bus.PKT_CNT0_O), WW'(1));
      chk("t2_cnt1", WW'(bus.PKT_CNT1_O), WW'(1));

      // 3: alternation of single-beat packets
      do_reset();
      for (int i = 0; i < 3; i++) begin
         s0_q.push_back({1'b1, 32'h30 + 32'(i)});
         s1_q.push_back({1'b1, 32'h40 + 32'(i)});
         exp_q.push_back(w(1, 0, 32'h30 + 32'(i)));
         exp_q.push_back(w(1, 1, 32'h40 + 32'(i)));
      end
      drain("t3");
      for (int i = 1; i < 6; i++) chk("t3_gap", WW'(wr_cyc[i] - wr_cyc[i-1]), WW'(2));
      chk("t3_cnt0", WW'(bus.PKT_CNT0_O), WW'(3));
      chk("t3_cnt1", WW'(bus.PKT_CNT1_O), WW'(3));

      // 4: back-pressure mid-packet for 4 cycles
      do_reset();
      for (int i = 0; i < 4; i++) begin
         s0_q.push_back({(i == 3), 32'hB0 + 32'(i)});
         exp_q.push_back(w(i == 3, 1'b0, 32'hB0 + 32'(i)));
      end
      for (int n = 0; n < 50 && wr_cyc.size() < 2; n++) begin
         @(posedge CLK_I);
         #2;
      end
      bus.FIFO_FULL_I = 1'b1;
      repeat (4) begin
         @(negedge CLK_I);
         chk("t4_ready", WW'(bus.S0_TREADY_O), '0);
         chk("t4_wr_en", WW'(bus.FIFO_WR_EN_O), '0);
         chk("t4_grant", WW'(bus.GRANT_O), WW'(2'b01));
      end
      @(posedge CLK_I);
      #2;
      bus.FIFO_FULL_I = 1'b0;
      drain("t4");
      chk("t4_cnt0", WW'(bus.PKT_CNT0_O), WW'(1));

      // 5: asynchronous reset in the middle of an S1 packet
      do_reset();
      for (int i = 0; i < 4; i++) s1_q.push_back({(i == 3), 32'hC0 + 32'(i)});
      exp_q.push_back(w(0, 1, 32'hC0));
      exp_q.push_back(w(0, 1, 32'hC1));
      for (int n = 0; n < 50 && wr_cyc.size() < 2; n++) begin
         @(posedge CLK_I);
         #2;
      end
      chk("t5_grant_pre", WW'(bus.GRANT_O), WW'(2'b10));
      RST_I = 1'b1;
      #1;
      chk("t5_grant_rst", WW'(bus.GRANT_O), '0);
      chk("t5_ready1_rst", WW'(bus.S1_TREADY_O), '0);
      s1_q.delete();
      repeat (2) @(negedge CLK_I);
      RST_I = 1'b0;
      chk("t5_pending", WW'(exp_q.size()), '0);
      chk("t5_cnt1", WW'(bus.PKT_CNT1_O), '0);
      s0_q.push_back({1'b1, 32'hD0});
      s1_q.push_back({1'b1, 32'hD1});
      exp_q.push_back(w(1, 0, 32'hD0));
      exp_q.push_back(w(1, 1, 32'hD1));
      drain("t5");

      // 6: counter wrap with a 2-bit counter
      do_reset();
      for (int i = 0; i < 5; i++) begin
         s0_q.push_back({1'b1, 32'hE0 + 32'(i)});
         exp_q.push_back(w(1, 0, 32'hE0 + 32'(i)));
         drain("t6");
         chk("t6_cnt0", WW'(bus.PKT_CNT0_O), WW'((i + 1) % 4));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
